// File: rtl/game_sequencer.sv
// Game controller for the VGA shooter: game FSM, per-frame ONPLAY stage pipeline,
// phase/difficulty counter and stage watchdog. Define PHASE_WRAP_EN for endless phase looping.
module game_sequencer #(
  parameter int unsigned MAX_ENEMY     = 15,
  parameter int unsigned ENEMY_CNT_W   = 4,
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned PHASE_W       = 2,
  parameter int unsigned MAX_PHASE_CNT = 124,
  parameter int unsigned PHASE_CNT_W   = 7,
  parameter int unsigned WDOG_CYCLES   = 1000,
  parameter int unsigned WDOG_W        = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_btn,
  input  logic                   frame_tick,
  input  logic                   stage_done,
  input  logic [ENEMY_CNT_W-1:0] enemy_alive_cnt,
  input  logic                   player_hit,
  output logic [2:0]             game_state,
  output logic [2:0]             onplay_state,
  output logic [PHASE_W-1:0]     phase,
  output logic [PHASE_CNT_W-1:0] phase_cnt,
  output logic                   stage_go,
  output logic                   game_init
);

  typedef enum logic [2:0] {
    GS_IDLE    = 3'b000,
    GS_PLAYING = 3'b001,
    GS_VICTORY = 3'b010,
    GS_DEFEAT  = 3'b011,
    GS_ERROR   = 3'b100
  } game_e;

  typedef enum logic [2:0] {
    OP_DRAW      = 3'b000,
    OP_MOVE      = 3'b001,
    OP_COLLISION = 3'b010,
    OP_CALCVALUE = 3'b011,
    OP_CHECKING  = 3'b100,
    OP_WAITING   = 3'b101
  } onplay_e;

  localparam logic [PHASE_W-1:0]     LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_CNT_W-1:0] LAST_CNT   = PHASE_CNT_W'(MAX_PHASE_CNT - 1);
  localparam logic [WDOG_W-1:0]      WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

  game_e                  r_game;
  onplay_e                r_onplay;
  logic [PHASE_W-1:0]     r_phase;
  logic [PHASE_CNT_W-1:0] r_phase_cnt;
  logic                   r_stage_go;
  logic                   r_game_init;
  logic                   r_btn_q;
  logic [WDOG_W-1:0]      r_wdog;

  logic w_start_edge;
  logic w_done_acc;
  logic w_wdog_exp;
  logic w_no_enemies;

  assign w_start_edge = start_btn & ~r_btn_q;
  // A done coinciding with the go pulse belongs to the previous stage and is dropped.
  assign w_done_acc   = stage_done & ~r_stage_go;
  assign w_wdog_exp   = (r_wdog == WDOG_LAST);
  assign w_no_enemies = (enemy_alive_cnt == '0) || (MAX_ENEMY == 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_game      <= GS_IDLE;
      r_onplay    <= OP_WAITING;
      r_phase     <= '0;
      r_phase_cnt <= '0;
      r_stage_go  <= 1'b0;
      r_game_init <= 1'b0;
      r_btn_q     <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_btn_q     <= start_btn;
      r_stage_go  <= 1'b0;
      r_game_init <= 1'b0;
      case (r_game)
        GS_IDLE: begin
          if (w_start_edge) begin
            r_game      <= GS_PLAYING;
            r_game_init <= 1'b1;
            r_onplay    <= OP_WAITING;
            r_phase     <= '0;
            r_phase_cnt <= '0;
          end
        end
        GS_PLAYING: begin
          case (r_onplay)
            OP_WAITING: begin
              if (frame_tick) begin
                r_onplay   <= OP_MOVE;
                r_stage_go <= 1'b1;
                r_wdog     <= '0;
              end
            end
            OP_MOVE, OP_COLLISION, OP_CALCVALUE, OP_DRAW: begin
              // Accepted done has priority over a simultaneous watchdog expiry.
              if (w_done_acc) begin
                r_wdog <= '0;
                case (r_onplay)
                  OP_MOVE: begin
                    r_onplay   <= OP_COLLISION;
                    r_stage_go <= 1'b1;
                  end
                  OP_COLLISION: begin
                    r_onplay   <= OP_CALCVALUE;
                    r_stage_go <= 1'b1;
                  end
                  OP_CALCVALUE: r_onplay <= OP_CHECKING;
                  default:      r_onplay <= OP_WAITING;
                endcase
              end else if (w_wdog_exp) begin
                r_game   <= GS_ERROR;
                r_onplay <= OP_WAITING;
                r_wdog   <= '0;
              end else begin
                r_wdog <= r_wdog + WDOG_W'(1);
              end
            end
            OP_CHECKING: begin
              if (player_hit) begin
                r_game   <= GS_DEFEAT;
                r_onplay <= OP_WAITING;
              end else if (w_no_enemies) begin
                r_game   <= GS_VICTORY;
                r_onplay <= OP_WAITING;
              end else begin
                r_onplay   <= OP_DRAW;
                r_stage_go <= 1'b1;
                r_wdog     <= '0;
                if (r_phase_cnt == LAST_CNT) begin
                  r_phase_cnt <= '0;
`ifdef PHASE_WRAP_EN
                  r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PHASE_W'(1);
`else
                  if (r_phase != LAST_PHASE) r_phase <= r_phase + PHASE_W'(1);
`endif
                end else begin
                  r_phase_cnt <= r_phase_cnt + PHASE_CNT_W'(1);
                end
              end
            end
            default: r_onplay <= OP_WAITING;
          endcase
        end
        GS_VICTORY, GS_DEFEAT, GS_ERROR: begin
          r_onplay <= OP_WAITING;
          if (w_start_edge) r_game <= GS_IDLE;
        end
        default: begin
          r_game   <= GS_IDLE;
          r_onplay <= OP_WAITING;
        end
      endcase
    end
  end

  assign game_state   = r_game;
  assign onplay_state = r_onplay;
  assign phase        = r_phase;
  assign phase_cnt    = r_phase_cnt;
  assign stage_go     = r_stage_go;
  assign game_init    = r_game_init;

endmodule
